sh_chain_dump_ctrl: RTL and testbench
=====================================

Name: sh_chain_dump_ctrl

Overview:
Parametrised shadow-capture and dump controller for the core's error-injection and shadow-scan infrastructure. On a capture trigger, with an optional programmable delay, it snapshots NUM_CHAINS parallel state chains into internal shadow registers. Each chain is then dumped independently, OUT_W bits per beat, over a valid/ready handshake with per-chain done flags. This generalises the fixed 32-chain, 1-bit, no-backpressure capture/dump interface to configurable chain count, chain length, beat width and trigger delay, and supports abort and re-dump.

Parameters:
NUM_CHAINS, 32, number of independent shadow chains
CHAIN_LEN, 64, bits per chain; must be a multiple of OUT_W
OUT_W, 1, bits emitted per chain per beat
DLY_W, 8, width of the capture-delay field
(derived) BEATS = CHAIN_LEN/OUT_W; BCNT_W = clog2(BEATS), minimum 1

Ports:
sh_clk  in  1  shadow/data clock; the only clock
sh_rst  in  1  reset, synchronous, active-high
c_en  in  1  capture trigger; rising edge is significant
cap_delay  in  DLY_W  cycles from trigger edge to snapshot; sampled on the trigger edge
chain_in  in  NUM_CHAINS*CHAIN_LEN  live chain state; chain i is bits [i*CHAIN_LEN +: CHAIN_LEN]
dump_en  in  NUM_CHAINS  per-chain dump request, level
sh_out_rdy  in  NUM_CHAINS  per-chain sink ready
sh_out  out  NUM_CHAINS*OUT_W  per-chain dump data; chain i is bits [i*OUT_W +: OUT_W]
sh_out_vld  out  NUM_CHAINS  per-chain data valid
sh_out_done  out  NUM_CHAINS  per-chain dump complete
cap_busy  out  1  capture delay in progress
cap_valid  out  1  shadow contents valid and dumpable

Behaviour:
- Reset: one clock, synchronous active-high. On sh_rst=1 at a clock edge, all outputs, shadow registers, counters and the c_en edge register go to 0. The global FSM goes to IDLE and every chain FSM to C_IDLE. Reset mid-delay or mid-dump aborts immediately, with no partial outputs after the reset edge.
- Trigger edge: trig = c_en & ~c_en_q, where c_en_q is c_en registered.
- Global FSM states: IDLE, DELAY, CAPTURED.
  - IDLE or CAPTURED, trig=1, no chain in C_SHIFT:
    - If cap_delay==0, shadow <= chain_in at this edge; go to CAPTURED.
    - Otherwise load dcnt <= cap_delay and go to DELAY.
  - In CAPTURED, a trig while any chain is in C_SHIFT is dropped, not queued.
  - DELAY: dcnt decrements each cycle. In the cycle where dcnt==1, shadow <= chain_in and the FSM goes to CAPTURED.
  - Net timing: with the trigger seen in cycle T, the chain_in value of cycle T+cap_delay is captured.
  - cap_busy = (state==DELAY). cap_valid = (state==CAPTURED). Both are registered state decodes.
- Per-chain FSM i, states C_IDLE, C_SHIFT, C_DONE:
  - C_IDLE -> C_SHIFT when dump_en[i]=1 and global state is CAPTURED. beat <= 0.
  - In C_SHIFT:
    - sh_out_vld[i]=1.
    - sh_out[i] = shadow[i][beat*OUT_W +: OUT_W], LSB-first.
    - beat increments on vld&rdy.
    - A handshake on beat BEATS-1 moves the chain to C_DONE.
  - If dump_en[i] drops while in C_SHIFT (abort), go to C_IDLE next cycle, vld=0, beat=0.
  - C_DONE: sh_out_done[i]=1 and vld=0. Return to C_IDLE when dump_en[i]=0.
  - dump_en[i] in any global state other than CAPTURED is ignored; chain stays in C_IDLE.
- Dump is non-destructive: shadow only changes on capture. A chain may be re-dumped any number of times.
- Data stability: while vld=1 and rdy=0, sh_out[i] holds.
- Chains are fully independent: different rdy patterns and concurrent dumps are allowed.
- A recapture may occur while chains sit in C_DONE; their done flags persist until dump_en drops.
- Counter widths: beat uses BCNT_W bits and never exceeds BEATS-1. dcnt uses DLY_W bits and never underflows.
- Outputs are registered or pure decodes of registered state. There is no combinational path from rdy to vld.

Test Plan:
- Reset: assert sh_rst 3 cycles mid-dump with default parameters -> next cycle all outputs are 0, cap_valid=0, and dump_en=1 gives no vld until a new capture.
- Zero delay: chain_in[63:0]=64'hA5A5_0000_FFFF_1234, c_en rises at T with cap_delay=0 -> cap_valid=1 at T+1. Then dump_en[0]=1 with rdy=1 -> 64 vld beats emitting bits 0..63 LSB-first, done[0]=1 after the last beat, vld=0.
- Delay: chain_in = cycle counter, cap_delay=5, trigger at T -> cap_busy=1 for T+1..T+5 and the captured value equals the counter at T+5. cap_delay=1 behaves identically with capture at T+1.
- Backpressure: OUT_W=4, CHAIN_LEN=16, rdy pattern 1,0,0,1,1,0,1 -> exactly 4 beats (nibbles 0..3 in order), sh_out stable while rdy=0, done after the 4th handshake.
- Abort and re-dump: drop dump_en[3] after 10 beats -> vld[3]=0 the next cycle. Reassert -> restarts at beat 0 and the full 64 bits are correct. A second dump after done also yields identical data.
- Concurrency:
  - Chain 0 at rdy=1 and chain 1 at rdy=50% run independently and both complete with correct data.
  - A c_en rise during their C_SHIFT is ignored and shadow is unchanged.
  - A c_en rise after both reach C_DONE recaptures new data.

Source files
------------

// File: rtl/sh_chain_dump_ctrl.sv
// ---------------------------------------------------------------------------
// sh_chain_dump_ctrl
//
// Shadow-capture and dump controller for the shadow-scan / error-injection
// infrastructure. A rising edge on c_en, optionally delayed by cap_delay
// cycles, snapshots NUM_CHAINS live state chains into shadow registers. Each
// chain is then dumped on its own, OUT_W bits per beat and LSB first, over a
// valid/ready handshake. Dumps never disturb the shadow, so a chain can be
// dumped again as often as needed.
//
// Ports:
//   sh_clk       clock (single clock domain)
//   sh_rst       synchronous active-high reset
//   c_en         capture trigger, rising edge significant
//   cap_delay    trigger-to-snapshot delay in cycles, sampled on the trigger
//   chain_in     live chain state, chain i at [i*CHAIN_LEN +: CHAIN_LEN]
//   dump_en      per-chain dump request (level)
//   sh_out_rdy   per-chain sink ready
//   sh_out       per-chain beat data, chain i at [i*OUT_W +: OUT_W]
//   sh_out_vld   per-chain beat valid
//   sh_out_done  per-chain dump complete, held until dump_en drops
//   cap_busy     capture delay in progress
//   cap_valid    shadow contents valid and dumpable
// ---------------------------------------------------------------------------
module sh_chain_dump_ctrl #(
    parameter int NUM_CHAINS = 32,
    parameter int CHAIN_LEN  = 64,
    parameter int OUT_W      = 1,
    parameter int DLY_W      = 8
) (
    input  logic                            sh_clk,
    input  logic                            sh_rst,
    input  logic                            c_en,
    input  logic [DLY_W-1:0]                cap_delay,
    input  logic [NUM_CHAINS*CHAIN_LEN-1:0] chain_in,
    input  logic [NUM_CHAINS-1:0]           dump_en,
    input  logic [NUM_CHAINS-1:0]           sh_out_rdy,
    output logic [NUM_CHAINS*OUT_W-1:0]     sh_out,
    output logic [NUM_CHAINS-1:0]           sh_out_vld,
    output logic [NUM_CHAINS-1:0]           sh_out_done,
    output logic                            cap_busy,
    output logic                            cap_valid
);

    localparam int BEATS  = CHAIN_LEN / OUT_W;
    localparam int BCNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DELAY    = 2'd1,
        CAPTURED = 2'd2
    } gstate_t;

    typedef enum logic [1:0] {
        C_IDLE  = 2'd0,
        C_SHIFT = 2'd1,
        C_DONE  = 2'd2
    } cstate_t;

    gstate_t                            gstate_r;
    gstate_t                            gstate_s;
    logic [DLY_W-1:0]                   dcnt_r;
    logic [DLY_W-1:0]                   dcnt_s;
    logic                               c_en_q_r;
    logic                               trig_s;
    logic                               any_shift_s;
    logic                               cap_start_s;
    logic                               cap_now_s;
    logic [NUM_CHAINS*CHAIN_LEN-1:0]    shadow_r;
    logic                               cap_busy_r;
    logic                               cap_valid_r;
    logic [NUM_CHAINS-1:0]              shifting_s;

    assign trig_s      = c_en & ~c_en_q_r;
    assign any_shift_s = |shifting_s;

    // Global capture FSM: next state, delay counter and capture strobes.
    always_comb begin
        gstate_s    = gstate_r;
        dcnt_s      = dcnt_r;
        cap_start_s = 1'b0;
        cap_now_s   = 1'b0;
        case (gstate_r)
            IDLE, CAPTURED: begin
                // A trigger while any chain is shifting is dropped so the
                // shadow never changes underneath an active dump.
                if (trig_s && !any_shift_s) begin
                    cap_start_s = 1'b1;
                    if (cap_delay == '0) begin
                        cap_now_s = 1'b1;
                        dcnt_s    = '0;
                        gstate_s  = CAPTURED;
                    end else begin
                        dcnt_s   = cap_delay;
                        gstate_s = DELAY;
                    end
                end else begin
                    gstate_s = gstate_r;
                end
            end
            DELAY: begin
                // Snapshot in the cycle the counter reads 1; <= guards
                // against underflow should the counter ever read 0.
                if (dcnt_r <= DLY_W'(1)) begin
                    cap_now_s = 1'b1;
                    dcnt_s    = '0;
                    gstate_s  = CAPTURED;
                end else begin
                    dcnt_s   = dcnt_r - DLY_W'(1);
                    gstate_s = DELAY;
                end
            end
            default: begin
                dcnt_s   = '0;
                gstate_s = IDLE;
            end
        endcase
    end

    // Global state, trigger edge register, shadow snapshot and status flags.
    always_ff @(posedge sh_clk) begin
        if (sh_rst) begin
            gstate_r    <= IDLE;
            dcnt_r      <= '0;
            c_en_q_r    <= 1'b0;
            shadow_r    <= '0;
            cap_busy_r  <= 1'b0;
            cap_valid_r <= 1'b0;
        end else begin
            gstate_r    <= gstate_s;
            dcnt_r      <= dcnt_s;
            c_en_q_r    <= c_en;
            if (cap_now_s) begin
                shadow_r <= chain_in;
            end
            cap_busy_r  <= (gstate_s == DELAY);
            cap_valid_r <= (gstate_s == CAPTURED);
        end
    end

    assign cap_busy  = cap_busy_r;
    assign cap_valid = cap_valid_r;

    for (genvar i = 0; i < NUM_CHAINS; i++) begin : g_chain
        cstate_t                       cs_r;
        cstate_t                       cs_s;
        logic [BCNT_W-1:0]             beat_r;
        logic [BCNT_W-1:0]             beat_s;
        logic                          last_s;
        logic [OUT_W-1:0]              out_r;
        logic                          vld_r;
        logic                          done_r;
        logic [BEATS-1:0][OUT_W-1:0]   beats_s;

        // Beat-indexed view of this chain's shadow slice.
        assign beats_s       = shadow_r[i*CHAIN_LEN +: CHAIN_LEN];
        assign shifting_s[i] = (cs_r == C_SHIFT);
        assign last_s        = (beat_r == BCNT_W'(BEATS - 1));

        // Per-chain dump FSM: next state and beat counter.
        always_comb begin
            cs_s   = cs_r;
            beat_s = beat_r;
            case (cs_r)
                C_IDLE: begin
                    beat_s = '0;
                    // Do not start in the cycle a capture is launched; the
                    // dump starts one cycle later against the fresh shadow.
                    if (dump_en[i] && (gstate_r == CAPTURED) && !cap_start_s) begin
                        cs_s = C_SHIFT;
                    end else begin
                        cs_s = C_IDLE;
                    end
                end
                C_SHIFT: begin
                    if (!dump_en[i]) begin
                        cs_s   = C_IDLE;
                        beat_s = '0;
                    end else if (sh_out_rdy[i]) begin
                        if (last_s) begin
                            cs_s   = C_DONE;
                            beat_s = '0;
                        end else begin
                            cs_s   = C_SHIFT;
                            beat_s = beat_r + BCNT_W'(1);
                        end
                    end else begin
                        cs_s   = C_SHIFT;
                        beat_s = beat_r;
                    end
                end
                C_DONE: begin
                    beat_s = '0;
                    if (!dump_en[i]) begin
                        cs_s = C_IDLE;
                    end else begin
                        cs_s = C_DONE;
                    end
                end
                default: begin
                    cs_s   = C_IDLE;
                    beat_s = '0;
                end
            endcase
        end

        // Per-chain state and registered outputs; data is preloaded with the
        // beat that will be presented in the next cycle.
        always_ff @(posedge sh_clk) begin
            if (sh_rst) begin
                cs_r   <= C_IDLE;
                beat_r <= '0;
                out_r  <= '0;
                vld_r  <= 1'b0;
                done_r <= 1'b0;
            end else begin
                cs_r   <= cs_s;
                beat_r <= beat_s;
                vld_r  <= (cs_s == C_SHIFT);
                done_r <= (cs_s == C_DONE);
                out_r  <= (cs_s == C_SHIFT) ? beats_s[beat_s] : '0;
            end
        end

        assign sh_out[i*OUT_W +: OUT_W] = out_r;
        assign sh_out_vld[i]            = vld_r;
        assign sh_out_done[i]           = done_r;
    end

endmodule

// File: tb/tb_sh_chain_dump_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sh_chain_dump_ctrl
//
// Directed bench for sh_chain_dump_ctrl. A default-parameter instance covers
// capture, delay, abort/re-dump, concurrency and reset; a small instance
// (2 chains of 16 bits, 4-bit beats) covers backpressure.
// ---------------------------------------------------------------------------
module tb_sh_chain_dump_ctrl;

    localparam int NC = 32;
    localparam int CL = 64;

    logic              sh_clk = 1'b0;
    logic              sh_rst;
    logic              c_en;
    logic [7:0]        cap_delay;
    logic [NC*CL-1:0]  chain_in;
    logic [NC-1:0]     dump_en;
    logic [NC-1:0]     sh_out_rdy;
    logic [NC-1:0]     sh_out;
    logic [NC-1:0]     sh_out_vld;
    logic [NC-1:0]     sh_out_done;
    logic              cap_busy;
    logic              cap_valid;

    logic              c_en4;
    logic [7:0]        cap_delay4;
    logic [31:0]       chain_in4;
    logic [1:0]        dump_en4;
    logic [1:0]        rdy4;
    logic [7:0]        out4;
    logic [1:0]        vld4;
    logic [1:0]        done4;
    logic              busy4;
    logic              valid4;

    int                tests = 0;
    int                fails = 0;
    int                cyc   = 0;
    bit                ctr_mode = 1'b0;
    logic [63:0]       got [NC];
    int                nbeat [NC];
    int                stab_err;
    int                to;
    int                t0;
    int                bad;
    logic [15:0]       bp_data;
    int                bp_n;
    int                bp_stab;
    logic              bp_hold;
    logic [3:0]        bp_prev;
    logic [6:0]        bp_pat;

    always #5 sh_clk = ~sh_clk;

    sh_chain_dump_ctrl u_dut (
        .sh_clk      (sh_clk),
        .sh_rst      (sh_rst),
        .c_en        (c_en),
        .cap_delay   (cap_delay),
        .chain_in    (chain_in),
        .dump_en     (dump_en),
        .sh_out_rdy  (sh_out_rdy),
        .sh_out      (sh_out),
        .sh_out_vld  (sh_out_vld),
        .sh_out_done (sh_out_done),
        .cap_busy    (cap_busy),
        .cap_valid   (cap_valid)
    );

    sh_chain_dump_ctrl #(
        .NUM_CHAINS (2),
        .CHAIN_LEN  (16),
        .OUT_W      (4),
        .DLY_W      (8)
    ) u_dut4 (
        .sh_clk      (sh_clk),
        .sh_rst      (sh_rst),
        .c_en        (c_en4),
        .cap_delay   (cap_delay4),
        .chain_in    (chain_in4),
        .dump_en     (dump_en4),
        .sh_out_rdy  (rdy4),
        .sh_out      (out4),
        .sh_out_vld  (vld4),
        .sh_out_done (done4),
        .cap_busy    (busy4),
        .cap_valid   (valid4)
    );

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge sh_clk);
        #1;
        cyc++;
        if (ctr_mode) chain_in[63:0] = 64'(cyc);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Dump the chains in mask; chains in rnd_mask get random ready, others
    // ready=1. Collects bits per chain and counts data changes under stall.
    task automatic run_dump(input logic [31:0] mask, input logic [31:0] rnd_mask,
                            input int maxc, output int timeout);
        logic [31:0] hold;
        logic [31:0] prev;
        hold = 32'h0;
        prev = 32'h0;
        for (int ch = 0; ch < NC; ch++) begin
            if (mask[ch]) begin
                got[ch]   = 64'h0;
                nbeat[ch] = 0;
            end
        end
        dump_en = dump_en | mask;
        timeout = 1;
        for (int c = 0; c < maxc; c++) begin
            tick();
            if ((sh_out_done & mask) == mask) begin
                timeout = 0;
                break;
            end
            for (int ch = 0; ch < NC; ch++) begin
                if (mask[ch]) begin
                    if (hold[ch] && (sh_out[ch] !== prev[ch])) stab_err++;
                    sh_out_rdy[ch] = rnd_mask[ch] ? 1'($urandom_range(0, 1)) : 1'b1;
                    if (sh_out_vld[ch] && sh_out_rdy[ch]) begin
                        if (nbeat[ch] < 64) got[ch][nbeat[ch]] = sh_out[ch];
                        nbeat[ch]++;
                    end
                    hold[ch] = sh_out_vld[ch] & ~sh_out_rdy[ch];
                    prev[ch] = sh_out[ch];
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sh_rst = 1'b1; c_en = 1'b0; cap_delay = 8'd0; chain_in = '0;
        dump_en = '0; sh_out_rdy = '0; stab_err = 0;
        c_en4 = 1'b0; cap_delay4 = 8'd0; chain_in4 = 32'h0; dump_en4 = 2'b00; rdy4 = 2'b00;
        tick(); tick();
        sh_rst = 1'b0;
        tick();
        check("rst_cap_valid", 64'(cap_valid), 64'd0);
        check("rst_cap_busy", 64'(cap_busy), 64'd0);
        check("rst_vld", 64'(sh_out_vld), 64'd0);
        check("rst_done", 64'(sh_out_done), 64'd0);
        check("rst_out", 64'(sh_out), 64'd0);

        // dump request before any capture is ignored
        dump_en[0] = 1'b1;
        tick(); tick();
        check("precap_vld", 64'(sh_out_vld), 64'd0);
        dump_en[0] = 1'b0;
        tick();

        // zero-delay capture and full dump of chain 0
        chain_in[63:0]    = 64'hA5A5_0000_FFFF_1234;
        chain_in[127:64]  = 64'h0123_4567_89AB_CDEF;
        chain_in[255:192] = 64'hDEAD_BEEF_CAFE_F00D;
        cap_delay = 8'd0;
        c_en = 1'b1;
        tick();
        c_en = 1'b0;
        check("zd_cap_valid", 64'(cap_valid), 64'd1);
        check("zd_cap_busy", 64'(cap_busy), 64'd0);
        run_dump(32'h1, 32'h0, 200, to);
        check("zd_timeout", 64'(to), 64'd0);
        check("zd_data", got[0], 64'hA5A5_0000_FFFF_1234);
        check("zd_beats", 64'(nbeat[0]), 64'd64);
        check("zd_vld_at_done", 64'(sh_out_vld[0]), 64'd0);
        check("zd_done", 64'(sh_out_done[0]), 64'd1);
        dump_en[0] = 1'b0;
        tick();
        check("zd_done_clr", 64'(sh_out_done[0]), 64'd0);

        // abort chain 3 after 10 beats, then re-dump twice
        dump_en[3] = 1'b1; sh_out_rdy[3] = 1'b1;
        tick();
        repeat (10) tick();
        check("ab_vld_before", 64'(sh_out_vld[3]), 64'd1);
        dump_en[3] = 1'b0;
        tick();
        check("ab_vld_after", 64'(sh_out_vld[3]), 64'd0);
        check("ab_done_after", 64'(sh_out_done[3]), 64'd0);
        run_dump(32'h8, 32'h0, 200, to);
        check("ab_redump_timeout", 64'(to), 64'd0);
        check("ab_redump_data", got[3], 64'hDEAD_BEEF_CAFE_F00D);
        check("ab_redump_beats", 64'(nbeat[3]), 64'd64);
        dump_en[3] = 1'b0;
        tick();
        run_dump(32'h8, 32'h8, 400, to);
        check("ab_second_timeout", 64'(to), 64'd0);
        check("ab_second_data", got[3], 64'hDEAD_BEEF_CAFE_F00D);
        dump_en[3] = 1'b0;
        tick();

        // delay 5: chain 0 follows the cycle counter
        ctr_mode = 1'b1;
        tick();
        cap_delay = 8'd5; c_en = 1'b1; t0 = cyc;
        tick();
        c_en = 1'b0;
        check("dl5_busy_t1", 64'(cap_busy), 64'd1);
        check("dl5_valid_t1", 64'(cap_valid), 64'd0);
        bad = 0;
        for (int k = 2; k <= 5; k++) begin
            tick();
            if (cap_busy !== 1'b1) bad++;
        end
        check("dl5_busy_t2_t5", 64'(bad), 64'd0);
        tick();
        check("dl5_busy_t6", 64'(cap_busy), 64'd0);
        check("dl5_valid_t6", 64'(cap_valid), 64'd1);
        ctr_mode = 1'b0;
        run_dump(32'h1, 32'h0, 200, to);
        check("dl5_timeout", 64'(to), 64'd0);
        check("dl5_data", got[0], 64'(t0 + 5));
        dump_en[0] = 1'b0;
        tick();

        // delay 1
        ctr_mode = 1'b1;
        tick();
        cap_delay = 8'd1; c_en = 1'b1; t0 = cyc;
        tick();
        c_en = 1'b0;
        check("dl1_busy_t1", 64'(cap_busy), 64'd1);
        tick();
        check("dl1_busy_t2", 64'(cap_busy), 64'd0);
        check("dl1_valid_t2", 64'(cap_valid), 64'd1);
        ctr_mode = 1'b0;
        run_dump(32'h1, 32'h0, 200, to);
        check("dl1_data", got[0], 64'(t0 + 1));
        dump_en[0] = 1'b0;
        tick();

        // backpressure on the 4-bit-beat instance
        chain_in4 = 32'h0000_C3A5;
        c_en4 = 1'b1;
        tick();
        c_en4 = 1'b0;
        check("bp_valid", 64'(valid4), 64'd1);
        check("bp_busy", 64'(busy4), 64'd0);
        dump_en4[0] = 1'b1; rdy4[0] = 1'b0;
        tick();
        bp_pat = 7'b1011001;
        bp_data = 16'h0; bp_n = 0; bp_stab = 0; bp_hold = 1'b0; bp_prev = 4'h0;
        for (int k = 0; k < 7; k++) begin
            rdy4[0] = bp_pat[k];
            if (bp_hold && (out4[3:0] !== bp_prev)) bp_stab++;
            if (vld4[0] && bp_pat[k]) begin
                if (bp_n < 4) bp_data[bp_n*4 +: 4] = out4[3:0];
                bp_n++;
            end
            bp_hold = vld4[0] & ~bp_pat[k];
            bp_prev = out4[3:0];
            tick();
        end
        check("bp_data", 64'(bp_data), 64'h0000_0000_0000_C3A5);
        check("bp_beats", 64'(bp_n), 64'd4);
        check("bp_stable", 64'(bp_stab), 64'd0);
        check("bp_done", 64'(done4[0]), 64'd1);
        check("bp_vld_end", 64'(vld4[0]), 64'd0);
        check("bp_chain1_idle", 64'({vld4[1], done4[1]}), 64'd0);
        dump_en4 = 2'b00;
        tick();

        // concurrency: recapture known data, run chains 0 and 1 together
        chain_in[63:0] = 64'hA5A5_0000_FFFF_1234;
        cap_delay = 8'd0; c_en = 1'b1;
        tick();
        c_en = 1'b0;
        check("cc_cap_valid", 64'(cap_valid), 64'd1);
        sh_out_rdy[1:0] = 2'b00; dump_en[1:0] = 2'b11;
        tick();
        check("cc_vld", 64'(sh_out_vld[1:0]), 64'd3);
        chain_in[63:0]   = 64'h0F0F_0F0F_F0F0_F0F0;
        chain_in[127:64] = 64'h8000_0000_0000_0001;
        c_en = 1'b1;
        tick();
        c_en = 1'b0;
        check("cc_trig_ign_valid", 64'(cap_valid), 64'd1);
        check("cc_trig_ign_busy", 64'(cap_busy), 64'd0);
        stab_err = 0;
        run_dump(32'h3, 32'h2, 600, to);
        check("cc_timeout", 64'(to), 64'd0);
        check("cc_data0", got[0], 64'hA5A5_0000_FFFF_1234);
        check("cc_data1", got[1], 64'h0123_4567_89AB_CDEF);
        check("cc_beats1", 64'(nbeat[1]), 64'd64);
        check("cc_stable", 64'(stab_err), 64'd0);
        tick();
        c_en = 1'b1;
        tick();
        c_en = 1'b0;
        check("cc_done_persist", 64'(sh_out_done[1:0]), 64'd3);
        check("cc_recap_valid", 64'(cap_valid), 64'd1);
        dump_en[1:0] = 2'b00;
        tick();
        run_dump(32'h1, 32'h0, 200, to);
        check("cc_recap_data", got[0], 64'h0F0F_0F0F_F0F0_F0F0);
        dump_en[0] = 1'b0;
        tick();

        // reset in the middle of a dump
        dump_en[0] = 1'b1; sh_out_rdy[0] = 1'b1;
        tick(); tick(); tick();
        check("rst2_vld_before", 64'(sh_out_vld[0]), 64'd1);
        sh_rst = 1'b1;
        tick();
        check("rst2_vld", 64'(sh_out_vld), 64'd0);
        check("rst2_out", 64'(sh_out), 64'd0);
        check("rst2_done", 64'(sh_out_done), 64'd0);
        check("rst2_valid", 64'(cap_valid), 64'd0);
        tick(); tick();
        sh_rst = 1'b0;
        tick(); tick(); tick();
        check("rst2_no_vld", 64'(sh_out_vld), 64'd0);
        check("rst2_no_valid", 64'(cap_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
